hex_scan_mux: RTL
=================

HEX_SCAN_MUX -- requirements
Module: hex_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 4, SHALL set the number of scanned digits (legal range 2..8).
REQ-002 Parameter REFRESH_BITS, default 18, SHALL set the refresh prescaler width (legal range 2..24).
REQ-003 Parameter ACTIVE_LOW, default 1, SHALL make an and sseg active-low when 1 and active-high when 0.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 hex_in  input  4*N_DIGITS  SHALL carry the digit values; digit i is hex_in[4i+3:4i], and digit 0 is least significant.
REQ-007 dp_in  input  N_DIGITS  SHALL carry the per-digit decimal point requests (1 = lit).
REQ-008 blank_in  input  N_DIGITS  SHALL carry the per-digit blank requests (1 = segments a-g off).
REQ-009 load  input  1  SHALL be the strobe that captures hex_in, dp_in and blank_in into the shadow registers.
REQ-010 lz_en  input  1  SHALL enable leading-zero suppression.
REQ-011 an  output  N_DIGITS  SHALL be the registered one-hot digit enable (polarity per ACTIVE_LOW).
REQ-012 sseg  output  8  SHALL be the registered segment output: bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a (polarity per ACTIVE_LOW).

Function
REQ-013 The refresh counter SHALL increment by 1 every clock and wrap from 2^REFRESH_BITS-1 to 0.
REQ-014 The tick SHALL be asserted in every cycle where the counter equals 2^REFRESH_BITS-1.
REQ-015 On tick, the digit index SHALL advance 0->1->...->N_DIGITS-1->0.
REQ-016 When load=1, the shadow registers SHALL capture hex_in, dp_in and blank_in at that edge; between loads they SHALL hold their value, so the display never tears.
REQ-017 Every clock, an and sseg SHALL be registered from the current index and the current shadow contents, giving one cycle of latency from any index or shadow change to the outputs.
REQ-018 Active-high segment codes (bits 6..0) SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-019 sseg[7] SHALL equal the shadow dp bit of the selected digit, regardless of blanking or suppression.
REQ-020 When the selected digit's shadow blank bit is 1, sseg[6:0] SHALL be all segments off.
REQ-021 When lz_en=1, digit i (i>=1) SHALL be suppressed (a-g off) if it and every higher digit are zero in the shadow register.
REQ-022 Digit 0 SHALL never be suppressed, so value 0 shows a single "0".
REQ-023 lz_en SHALL be sampled live, not shadowed.
REQ-024 an SHALL have exactly one digit active, at position index, in every cycle except the reset cycle and the first cycle after it.
REQ-025 When load and tick occur in the same cycle, both SHALL take effect; the next output cycle shows the new index with the new data.
REQ-026 With ACTIVE_LOW=1, an and sseg SHALL be the bitwise inverse of the active-high values.

Reset
REQ-027 While reset=1 at an edge, the counter, index and shadow registers SHALL clear to 0.
REQ-028 While reset=1 at an edge, an SHALL be all digits off and sseg all segments off (0xFF for ACTIVE_LOW=1).
REQ-029 Reset SHALL take priority over load and tick.
REQ-030 A reset asserted mid-scan SHALL abort the scan, and scanning SHALL restart at digit 0 with a full refresh period.
REQ-031 In the first cycle after reset deasserts, outputs SHALL remain off.
REQ-032 From the second cycle after reset deasserts, outputs SHALL show digit 0 with value 0: sseg=0xC0, an=4'b1110 for N_DIGITS=4, ACTIVE_LOW=1.

Verification (N_DIGITS=4, REFRESH_BITS=2, ACTIVE_LOW=1)
REQ-033 Reset, then load hex_in=16'h1234, dp_in=0, blank_in=0 -> an SHALL sequence 1110,1101,1011,0111 with each value held 4 cycles, and sseg SHALL be 0x99,0xB0,0xA4,0xF9 respectively.
REQ-034 Load hex_in=16'h00A0 with lz_en=1 -> digits 3 and 2 SHALL be 0xFF, digit 1 SHALL be 0x88, and digit 0 SHALL be 0xC0.
REQ-035 Load hex_in=0, lz_en=1, dp_in=4'b0100 -> digit 2 SHALL be 0x7F and digits 3 and 1 SHALL be 0xFF.
REQ-036 Change hex_in without load -> sseg SHALL be unchanged; then pulse load coincident with tick -> the next digit SHALL show the new value one cycle later.
REQ-037 Assert reset while index=2 -> the next edge SHALL give an=1111 and sseg=0xFF, and the scan SHALL resume at digit 0 with a full 4-cycle dwell.
REQ-038 Sweep all 16 values on digit 0 with ACTIVE_LOW=0 -> sseg[6:0] SHALL match the REQ-018 table exactly.

Source files
------------

// File: rtl/hex_scan_mux.sv
// Multiplexed hex display driver: scans N_DIGITS seven-segment digits from a
// load-strobed shadow register, with per-digit decimal point, blanking and
// optional leading-zero suppression. an/sseg are registered outputs.
module hex_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_BITS = 18,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg
);

  localparam int                 IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic               POL_LOW  = (ACTIVE_LOW != 0);
  // "Off" patterns double as the polarity masks: XOR with them converts
  // active-high values into the configured output polarity.
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{POL_LOW}};
  localparam logic [7:0]          SSEG_OFF = {8{POL_LOW}};

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic                    tick;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   hex_q, hex_d;
  logic [N_DIGITS-1:0]     dp_q, dp_d;
  logic [N_DIGITS-1:0]     blank_q, blank_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic [N_DIGITS-1:0]     lead_zero;
  logic                    zero_run;
  logic [3:0]              sel_hex;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    sel_lz;
  logic [N_DIGITS-1:0]     an_hi;
  logic [6:0]              seg_hi;

  // Refresh prescaler and digit index: advance one digit per counter wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q + REFRESH_BITS'(1);
    tick  = &cnt_q;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow registers follow the inputs only on a load strobe, so a digit
  // never shows a half-updated value.
  always_comb begin
    hex_d   = hex_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (load) begin
      hex_d   = hex_in;
      dp_d    = dp_in;
      blank_d = blank_in;
    end
  end

  // lead_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (hex_q[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  // Select the scanned digit and build the next an/sseg values.
  always_comb begin
    sel_hex   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_lz    = 1'b0;
    an_hi     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_hex   = hex_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_blank = blank_q[i];
        // Digit 0 is never suppressed so a zero value still shows "0".
        sel_lz    = (i != 0) && lead_zero[i];
        an_hi[i]  = 1'b1;
      end
    end
    // lz_en is used live; dp is kept even on blanked or suppressed digits.
    seg_hi = (sel_blank || (lz_en && sel_lz)) ? 7'h00 : seg_decode(sel_hex);
    an_d   = an_hi ^ AN_OFF;
    sseg_d = {sel_dp, seg_hi} ^ SSEG_OFF;
  end

  // Counter and index registers; reset restarts the scan at digit 0.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else begin
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
    end
  end

  // Output registers: one cycle behind index and shadow contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= AN_OFF;
      sseg_q <= SSEG_OFF;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule
